// File: rtl/jpeg_dec_pkg.sv
// Shared constants and types for the JPEG decode path: coefficient width,
// block size and the zigzag-index to raster-address lookup.
package jpeg_dec_pkg;

  localparam int COEF_W_DEF   = 12;
  localparam int BLK_SIZE_DEF = 64;

  typedef logic       bank_t;
  typedef logic [5:0] cidx_t;

  localparam cidx_t LAST_IDX = 6'd63;

  localparam cidx_t ZZ2RASTER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/idct_dezigzag_chk.sv
// Protocol invariants for the ping-pong buffer: no write into a full bank,
// no read from an empty bank, never both sides on one bank in a cycle.
module idct_dezigzag_chk
  import jpeg_dec_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       wr_acc,
  input bank_t      wr_bank,
  input logic       rd_load,
  input bank_t      rd_bank,
  input logic [1:0] full
);

  a_no_write_into_full : assert property (@(posedge clk) disable iff (!rst)
    wr_acc |-> !full[wr_bank])
    else $error("write accepted into a full bank");

  a_no_read_from_empty : assert property (@(posedge clk) disable iff (!rst)
    rd_load |-> full[rd_bank])
    else $error("read load from a bank that is not full");

  a_banks_disjoint : assert property (@(posedge clk) disable iff (!rst)
    (wr_acc && rd_load) |-> (wr_bank != rd_bank))
    else $error("write and read target the same bank");

endmodule

// File: rtl/jpeg_zz_rom.sv
// Combinational zigzag-index to raster-address map, shared with the
// encoder-side checkers.
module jpeg_zz_rom
  import jpeg_dec_pkg::*;
(
  input  cidx_t zz_idx,
  output cidx_t raster_addr
);

  assign raster_addr = ZZ2RASTER[zz_idx];

endmodule

// File: rtl/idct_dezigzag.sv
// Inverse zigzag reorder buffer: zigzag-ordered 8x8 coefficient blocks in,
// raster-ordered blocks out, double-buffered with valid/ready on both sides.
module idct_dezigzag
  import jpeg_dec_pkg::*;
#(
  parameter int COEF_W   = COEF_W_DEF,
  parameter int BLK_SIZE = BLK_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              din_sof,
  input  logic [COEF_W-1:0] din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [COEF_W-1:0] dout,
  output logic              dout_sof,
  output logic              dout_eob
);

  logic [COEF_W-1:0] mem_q [2][BLK_SIZE];

  logic [1:0]        full_q, full_d;
  bank_t             wr_bank_q, wr_bank_d;
  bank_t             rd_bank_q, rd_bank_d;
  cidx_t             wr_cnt_q, wr_cnt_d;
  cidx_t             rd_cnt_q, rd_cnt_d;
  logic              dout_valid_q, dout_valid_d;
  logic [COEF_W-1:0] dout_q, dout_d;
  logic              dout_sof_q, dout_sof_d;
  logic              dout_eob_q, dout_eob_d;

  logic              wr_acc_s;
  logic              wr_last_s;
  cidx_t             wr_idx_s;
  cidx_t             wr_addr_s;
  logic              rd_load_s;
  logic              rd_last_s;

  assign din_ready  = ~full_q[wr_bank_q];
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eob   = dout_eob_q;

  jpeg_zz_rom u_zz_rom (
    .zz_idx      (wr_idx_s),
    .raster_addr (wr_addr_s)
  );

  // Write side: a sof restarts the block at index 0, discarding any partial one.
  always_comb begin
    wr_acc_s  = din_valid & din_ready;
    wr_idx_s  = din_sof ? 6'd0 : wr_cnt_q;
    wr_last_s = wr_acc_s & (wr_idx_s == LAST_IDX);
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_last_s) begin
      wr_cnt_d  = 6'd0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_acc_s) begin
      wr_cnt_d  = wr_idx_s + 6'd1;
    end else begin
      wr_cnt_d  = wr_cnt_q;
    end
  end

  // Read side: output register refills whenever it is empty or being consumed.
  always_comb begin
    rd_load_s    = full_q[rd_bank_q] & (~dout_valid_q | dout_ready);
    rd_last_s    = rd_load_s & (rd_cnt_q == LAST_IDX);
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    dout_sof_d   = dout_sof_q;
    dout_eob_d   = dout_eob_q;
    if (rd_load_s) begin
      dout_d       = mem_q[rd_bank_q][rd_cnt_q];
      dout_sof_d   = (rd_cnt_q == 6'd0);
      dout_eob_d   = (rd_cnt_q == LAST_IDX);
      dout_valid_d = 1'b1;
      if (rd_last_s) begin
        rd_cnt_d  = 6'd0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d  = rd_cnt_q + 6'd1;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // Bank occupancy; set and clear always hit different banks when coincident.
  always_comb begin
    full_d = full_q;
    if (wr_last_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_q[wr_bank_q];
    end
    if (rd_last_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end
  end

  // Coefficient storage, contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_bank_q][wr_addr_s] <= din;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= 6'd0;
      rd_cnt_q     <= 6'd0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_sof_q   <= 1'b0;
      dout_eob_q   <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_sof_q   <= dout_sof_d;
      dout_eob_q   <= dout_eob_d;
    end
  end

  idct_dezigzag_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .wr_acc  (wr_acc_s),
    .wr_bank (wr_bank_q),
    .rd_load (rd_load_s),
    .rd_bank (rd_bank_q),
    .full    (full_q)
  );

endmodule

// File: doc/idct_dezigzag.md
Name: idct_dezigzag

Overview:
Inverse zigzag reorder buffer for the JPEG decode path. It mirrors the encoder's fdct_zigzag stage. It accepts 8x8 coefficient blocks in zigzag scan order and emits them in raster (row-major) order toward the IDCT.
- Double-buffered (ping-pong), so a new block can be written while the previous one is being read.
- Valid/ready handshake on both sides.

Parameters:
COEF_W, 12, coefficient width in bits (signed, passed through unmodified)
BLK_SIZE, 64, coefficients per block (fixed 8x8; other values unsupported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
din_valid  input  1  input coefficient valid
din_ready  output  1  buffer can accept input
din_sof  input  1  qualifies din as zigzag index 0 of a new block
din  input  COEF_W  coefficient, zigzag order
dout_valid  output  1  output coefficient valid
dout_ready  input  1  downstream accepts output
dout  output  COEF_W  coefficient, raster order
dout_sof  output  1  dout is raster index 0
dout_eob  output  1  dout is raster index 63

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=0.
  - dout_valid=0, dout=0, dout_sof=0, dout_eob=0.
  - din_ready returns 1 in the first cycle after deassertion.
  - Storage contents are don't-care.
  - Reset mid-block discards all partial and full blocks.
- Storage: 2 banks x 64 x COEF_W flops.
- Write side:
  - din_ready = !full[wr_bank]. This is combinational from registered state only, and never depends on din_valid.
  - On accept (din_valid & din_ready), write din to bank[wr_bank][ZZ2RASTER[idx]].
  - idx is 0 if din_sof=1, else wr_cnt.
  - wr_cnt becomes idx+1.
- Block completion on the write side:
  - When idx==63 is accepted: full[wr_bank] is set, wr_bank toggles, wr_cnt goes to 0.
  - din_sof while wr_cnt!=0 discards the partial block. That element is written as index 0 of the restarted block.
  - din_sof is ignored for indexing when wr_cnt==0, apart from forcing idx=0.
- Read side (output register):
  - The register loads when full[rd_bank] & (!dout_valid | dout_ready).
  - Loaded values: dout = bank[rd_bank][rd_cnt], dout_sof = (rd_cnt==0), dout_eob = (rd_cnt==63), dout_valid = 1. rd_cnt then increments.
  - When rd_cnt==63 is loaded: full[rd_bank] is cleared, rd_bank toggles, rd_cnt goes to 0.
  - If no load occurs and dout_ready=1, dout_valid goes to 0.
  - dout, dout_sof and dout_eob stay stable while dout_valid & !dout_ready.
- Latency: 64th input accepted at edge N gives dout_valid=1 with raster index 0 after edge N+1.
  - Sustained throughput is 1 coefficient/cycle on each side.
  - With dout_ready held at 1, a continuous input stream never stalls.
- Boundary conditions:
  - Both banks full: din_ready=0 until the read side frees a bank. The freeing happens on the edge that loads index 63. din_ready rises in the next cycle.
  - Same-edge set of full[wr_bank] and clear of full[rd_bank]: these are different banks and both take effect.
  - Write and read never target the same bank in the same cycle.
- Invariant: full never exceeds 2 blocks. A write into a full bank is impossible by construction and must be asserted.

Decomposition:
- Shared package jpeg_dec_pkg:
  - COEF_W default constant and BLK_SIZE.
  - ZZ2RASTER[0:63] lookup constant: 0,1,8,16,9,2,3,10,17,24,...
  - bank index typedef (1 bit) and coefficient index typedef (6 bits).
- Sub-module jpeg_zz_rom: combinational 6-bit zigzag-index to raster-address map. It is reused by the encoder-side checkers.

Test Plan:
- Reset release, then one block with din = zigzag index k (0..63) and dout_ready=1 -> dout row 0 is 0,1,5,6,14,15,27,28 and row 1 is 2,4,7,13,16,26,29,42. dout_sof on the first output and dout_eob on the 64th. First dout_valid 1 cycle after the 64th accept.
- Three back-to-back blocks, din_valid=1 continuously, dout_ready=0 -> din_ready drops after 128 accepts. Set dout_ready=1 -> din_ready returns 1 cycle after the 64th output load. No data lost or duplicated across the 192 outputs.
- Random dout_ready (50%) with continuous input of block values 100+k -> dout holds stable while stalled. Order matches ZZ2RASTER. Every block has exactly 64 outputs.
- din_sof asserted at wr_cnt=20 with a new block of value 500+k -> the partial block is discarded and only the 500+k block appears in raster order.
- Assert rst low mid-read (rd_cnt=30) and mid-write (wr_cnt=10) -> all outputs 0 and dout_valid=0 immediately. After release, a fresh block is output correctly with no remnants.
